// File: rtl/blake_pkg.sv
// Shared constants, FSM encoding and width helper for the Blake-512 round sequencer.
package blake_pkg;

  localparam int NUM_ROUNDS_512 = 16;
  localparam int SIGMA_MOD      = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // A single-step round still needs a 1-bit step index.
  function automatic int step_width(input int steps);
    if (steps <= 1) begin
      return 1;
    end else begin
      return $clog2(steps);
    end
  endfunction

endpackage

// File: rtl/blake_round_ctrl_if.sv
// Start/result handshake and round-sequencing bus between the controller and the 2G core.
interface blake_round_ctrl_if #(
  parameter int ROUND_W = 4,
  parameter int STEP_W  = 1
) ();

  logic               start_valid;
  logic               start_ready;
  logic               abort;
  logic               init_round;
  logic               round_ing;
  logic [ROUND_W-1:0] round_idx;
  logic [STEP_W-1:0]  step_idx;
  logic [3:0]         sigma_idx;
  logic               finalize;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output start_valid, abort, out_ready,
    input  start_ready, init_round, round_ing, round_idx, step_idx,
           sigma_idx, finalize, out_valid, busy
  );

  modport slave (
    input  start_valid, abort, out_ready,
    output start_ready, init_round, round_ing, round_idx, step_idx,
           sigma_idx, finalize, out_valid, busy
  );

endinterface

// File: rtl/blake_round_cnt.sv
// Step/round/sigma counter chain; sigma wraps with its own counter so no modulo is needed.
module blake_round_cnt #(
  parameter int NUM_ROUNDS      = 16,
  parameter int STEPS_PER_ROUND = 2,
  parameter int ROUND_W         = 4,
  parameter int SIGMA_MOD       = 10,
  parameter int STEP_W          = 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               clr,
  input  logic               adv,
  output logic [ROUND_W-1:0] round_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic [3:0]         sigma_idx,
  output logic               last_step
);

  logic [ROUND_W-1:0] round_r;
  logic [STEP_W-1:0]  step_r;
  logic [3:0]         sigma_r;
  logic               step_wrap_s;
  logic               last_step_s;

  // Detect the end of a round and the end of the whole compression.
  always_comb begin
    step_wrap_s = (step_r == STEP_W'(STEPS_PER_ROUND - 1));
    last_step_s = step_wrap_s && (round_r == ROUND_W'(NUM_ROUNDS - 1));
  end

  // Counter registers: clear dominates advance.
  always_ff @(posedge clk) begin
    if (rstb || clr) begin
      round_r <= '0;
      step_r  <= '0;
      sigma_r <= 4'd0;
    end else if (adv) begin
      if (step_wrap_s) begin
        step_r  <= '0;
        round_r <= round_r + ROUND_W'(1);
        sigma_r <= (sigma_r == 4'(SIGMA_MOD - 1)) ? 4'd0 : (sigma_r + 4'd1);
      end else begin
        step_r  <= step_r + STEP_W'(1);
      end
    end
  end

  assign round_idx = round_r;
  assign step_idx  = step_r;
  assign sigma_idx = sigma_r;
  assign last_step = last_step_s;

endmodule

// File: rtl/blake_round_ctrl.sv
// Sequencer for one Blake-512 compression: init, NUM_ROUNDS x STEPS_PER_ROUND G-steps, finalize, result handshake.
module blake_round_ctrl #(
  parameter int NUM_ROUNDS      = blake_pkg::NUM_ROUNDS_512,
  parameter int STEPS_PER_ROUND = 2,
  parameter int ROUND_W         = 4,
  parameter int SIGMA_MOD       = blake_pkg::SIGMA_MOD
) (
  input  logic               clk,
  input  logic               rstb,
  blake_round_ctrl_if.slave  bus
);

  import blake_pkg::*;

  localparam int STEP_W = step_width(STEPS_PER_ROUND);

  ctrl_state_e state_r;
  ctrl_state_e state_s;
  logic        last_step_s;
  logic        cnt_clr_s;
  logic        cnt_adv_s;
  logic        start_ready_r;
  logic        init_round_r;
  logic        round_ing_r;
  logic        finalize_r;
  logic        out_valid_r;
  logic        busy_r;

  // Next-state selection; abort returns to IDLE from anywhere.
  always_comb begin
    state_s = state_r;
    if (bus.abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start_valid) state_s = ST_INIT;
          else                 state_s = ST_IDLE;
        end
        ST_INIT:  state_s = ST_ROUND;
        ST_ROUND: begin
          if (last_step_s) state_s = ST_FINAL;
          else             state_s = ST_ROUND;
        end
        ST_FINAL: state_s = ST_DONE;
        ST_DONE: begin
          if (bus.out_ready) state_s = ST_IDLE;
          else               state_s = ST_DONE;
        end
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Counters only live while we stay in ROUND; leaving ROUND zeroes them.
  always_comb begin
    cnt_adv_s = (state_r == ST_ROUND);
    cnt_clr_s = (state_s != ST_ROUND);
  end

  // State register plus flopped outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_r       <= ST_IDLE;
      start_ready_r <= 1'b1;
      init_round_r  <= 1'b0;
      round_ing_r   <= 1'b0;
      finalize_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_ready_r <= (state_s == ST_IDLE);
      init_round_r  <= (state_s == ST_INIT);
      round_ing_r   <= (state_s == ST_ROUND);
      finalize_r    <= (state_s == ST_FINAL);
      out_valid_r   <= (state_s == ST_DONE);
      busy_r        <= (state_s != ST_IDLE);
    end
  end

  blake_round_cnt #(
    .NUM_ROUNDS      (NUM_ROUNDS),
    .STEPS_PER_ROUND (STEPS_PER_ROUND),
    .ROUND_W         (ROUND_W),
    .SIGMA_MOD       (SIGMA_MOD),
    .STEP_W          (STEP_W)
  ) u_cnt (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (cnt_clr_s),
    .adv       (cnt_adv_s),
    .round_idx (bus.round_idx),
    .step_idx  (bus.step_idx),
    .sigma_idx (bus.sigma_idx),
    .last_step (last_step_s)
  );

  assign bus.start_ready = start_ready_r;
  assign bus.init_round  = init_round_r;
  assign bus.round_ing   = round_ing_r;
  assign bus.finalize    = finalize_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed scenarios plus random traffic, checked each cycle against a cycles-since-start reference model.
module tb_blake_round_ctrl;

  localparam int NR  = 16;
  localparam int SPR = 2;
  localparam int SM  = 10;
  localparam int RS  = NR * SPR;

  logic clk = 1'b0;
  logic rstb;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: is a compression in flight, and how many cycles since its accept.
  bit   m_act = 1'b0;
  int   m_t   = 0;

  int   cnt_ov, cnt_fin, cnt_init;

  blake_round_ctrl_if #(.ROUND_W(4), .STEP_W(1)) bus ();

  blake_round_ctrl #(
    .NUM_ROUNDS      (NR),
    .STEPS_PER_ROUND (SPR),
    .ROUND_W         (4),
    .SIGMA_MOD       (SM)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic sv, input logic ab, input logic ordy, input logic rs);
    if (rs || ab) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      if (sv) begin
        m_act = 1'b1;
        m_t   = 1;
      end
    end else if (m_t >= RS + 3) begin
      if (ordy) m_act = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_all();
    int k;
    int e_round = 0;
    int e_step  = 0;
    int e_sig   = 0;
    bit e_rnd;
    e_rnd = m_act && (m_t >= 2) && (m_t <= RS + 1);
    if (e_rnd) begin
      k       = m_t - 2;
      e_round = k / SPR;
      e_step  = k % SPR;
      e_sig   = e_round % SM;
    end
    check("start_ready", 32'(bus.start_ready), 32'(!m_act));
    check("init_round",  32'(bus.init_round),  32'(m_act && m_t == 1));
    check("round_ing",   32'(bus.round_ing),   32'(e_rnd));
    check("finalize",    32'(bus.finalize),    32'(m_act && m_t == RS + 2));
    check("out_valid",   32'(bus.out_valid),   32'(m_act && m_t >= RS + 3));
    check("busy",        32'(bus.busy),        32'(m_act));
    check("round_idx",   32'(bus.round_idx),   32'(e_round));
    check("step_idx",    32'(bus.step_idx),    32'(e_step));
    check("sigma_idx",   32'(bus.sigma_idx),   32'(e_sig));
  endtask

  // Apply inputs for the coming edge, advance the model with them, then compare just after the edge.
  task automatic step_cyc(input logic sv, input logic ab, input logic ordy, input logic rs);
    bus.start_valid = sv;
    bus.abort       = ab;
    bus.out_ready   = ordy;
    rstb            = rs;
    @(posedge clk);
    model_update(sv, ab, ordy, rs);
    #1;
    compare_all();
    if (bus.out_valid)  cnt_ov++;
    if (bus.finalize)   cnt_fin++;
    if (bus.init_round) cnt_init++;
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.out_ready   = 1'b0;
    rstb            = 1'b1;
    step_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    step_cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_ready", 32'(bus.start_ready), 32'd1);

    // Nominal run: the accepting edge ends cycle 0, so the first sample is cycle 1.
    step_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("nom_init_c1", 32'(bus.init_round), 32'd1);
    for (int c = 2; c <= 36; c++) begin
      step_cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (c == 21) check("sig_c21", 32'({bus.round_idx, bus.step_idx, bus.sigma_idx}), 32'({4'd9, 1'b1, 4'd9}));
      if (c == 22) check("sig_c22", 32'({bus.round_idx, bus.step_idx, bus.sigma_idx}), 32'({4'd10, 1'b0, 4'd0}));
      if (c == 33) check("sig_c33", 32'({bus.round_idx, bus.step_idx, bus.sigma_idx}), 32'({4'd15, 1'b1, 4'd5}));
      if (c == 34) check("nom_fin_c34", 32'(bus.finalize), 32'd1);
      if (c == 35) check("nom_ov_c35", 32'(bus.out_valid), 32'd1);
      if (c == 36) check("nom_ready_c36", 32'(bus.start_ready), 32'd1);
    end

    // Backpressure: five refused DONE edges, then accept; start_valid held the whole time.
    cnt_ov = 0; cnt_fin = 0; cnt_init = 0;
    step_cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 45; c++) begin
      step_cyc(1'(c <= 41), 1'b0, 1'(c >= 41), 1'b0);
    end
    check("bp_ov_cycles", 32'(cnt_ov), 32'd6);
    check("bp_fin_count", 32'(cnt_fin), 32'd1);
    check("bp_init_count", 32'(cnt_init), 32'd1);

    // Abort at cycle 16 (round 7, step 0).
    cnt_ov = 0; cnt_fin = 0;
    step_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) step_cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("ab_pre_round", 32'(bus.round_idx), 32'd7);
    step_cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("ab_idle", 32'({bus.start_ready, bus.busy, bus.round_idx}), 32'({1'b1, 1'b0, 4'd0}));
    for (int c = 18; c <= 40; c++) step_cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("ab_no_fin_ov", 32'(cnt_ov + cnt_fin), 32'd0);
    for (int c = 0; c < 36; c++) step_cyc(1'(c == 0), 1'b0, 1'b1, 1'b0);
    check("ab_rerun_fin", 32'(cnt_fin), 32'd1);

    // Reset together with abort at cycle 20.
    step_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 2; c <= 20; c++) step_cyc(1'b0, 1'b0, 1'b1, 1'b0);
    step_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_outs", 32'({bus.start_ready, bus.init_round, bus.round_ing, bus.finalize, bus.out_valid, bus.busy}),
          32'(6'b100000));
    cnt_init = 0;
    for (int c = 0; c < 40; c++) step_cyc(1'(c == 0), 1'b0, 1'b1, 1'b0);
    check("rst_init_once", 32'(cnt_init), 32'd1);

    // Continuous start_valid: one accept every 36 cycles.
    cnt_init = 0;
    for (int c = 0; c < 108; c++) step_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("busy_inits", 32'(cnt_init), 32'd3);

    // Random traffic including rare aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      step_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blake_round_ctrl.md
Name: blake_round_ctrl

Overview:
- Sequencer for one Blake-512 compression on the duplicated 2G core.
- Accepts a start handshake and pulses init_round to load the 640-bit message buffer and initialise the state matrix.
- Drives round_ing, round index, G-step index and sigma-permutation index for NUM_ROUNDS rounds, then a one-cycle finalize (feed-forward).
- Presents a valid/ready result handshake to downstream compare/output logic.

Parameters:
- NUM_ROUNDS, 16, rounds per compression; must be ≤ 2**ROUND_W.
- STEPS_PER_ROUND, 2, G-steps per round (column step, then diagonal step); must be ≥ 1.
- ROUND_W, 4, width of round_idx.
- SIGMA_MOD, 10, sigma table period; sigma_idx = round mod SIGMA_MOD.

Ports:
- clk  in  1  core clock.
- rstb  in  1  reset; synchronous, active-high.
- start_valid  in  1  new message block present on din_swapped.
- start_ready  out  1  controller idle and able to accept a start.
- abort  in  1  synchronous cancel; overrides all other inputs.
- init_round  out  1  one-cycle load enable for the message buffer and state init.
- round_ing  out  1  high during every G-step cycle.
- round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1.
- step_idx  out  1  0 = column step, 1 = diagonal step (width clog2(STEPS_PER_ROUND), min 1).
- sigma_idx  out  4  message permutation row, 0..SIGMA_MOD-1.
- finalize  out  1  one-cycle feed-forward enable.
- out_valid  out  1  hash result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, INIT, ROUND, FINAL, DONE; encoded in a registered state variable.
- Reset: rstb high at a clock edge sets state=IDLE and all counters to 0.
  - Outputs from the next cycle: start_ready=1; all other outputs 0.
- IDLE: start_ready=1. If start_valid is high at a clock edge (call it cycle 0), state goes to INIT.
- INIT (cycle 1): init_round=1 for exactly one cycle; counters are 0. Next state is ROUND.
- ROUND (cycles 2 .. 1+NUM_ROUNDS*STEPS_PER_ROUND, i.e. 2..33 with defaults): round_ing=1.
  - Each cycle step_idx increments.
  - At step STEPS_PER_ROUND-1, step_idx wraps to 0, round_idx increments, and sigma_idx increments.
  - sigma_idx wraps SIGMA_MOD-1 → 0 using a separate counter; no divider.
  - At the last step of round NUM_ROUNDS-1, next state is FINAL. round_idx never reaches NUM_ROUNDS.
- FINAL (cycle 34): finalize=1 for one cycle, round_ing=0, and all counters clear to 0. Next state is DONE.
- DONE (cycle 35 onward): out_valid=1, held stable until out_ready is high at a clock edge; then next state is IDLE.
  - out_ready high on the first DONE cycle gives a minimum accept-to-accept spacing of 36 cycles.
- Handshakes:
  - start_ready is low in every state except IDLE. start_valid outside IDLE is ignored, with no queuing.
  - out_ready outside DONE is ignored.
  - No back-to-back overlap: a new start is accepted only in IDLE, the cycle after the DONE handshake.
- Abort: high at any edge forces IDLE and clears counters next cycle, with no finalize and no out_valid. Abort in IDLE ignores start_valid on that edge.
- Priority: rstb > abort > normal transitions.
- Idle values: round_idx, step_idx and sigma_idx read 0 outside ROUND.
- Output timing: all outputs are registered or decoded purely from state. There is no combinational path from any input to any output.

Decomposition:
- Package blake_pkg holds:
  - the state encoding constants;
  - NUM_ROUNDS_512=16 and SIGMA_MOD=10;
  - a function computing the step_idx width.
- Sub-module blake_round_cnt holds the step/round/sigma counter chain, with inputs clr and adv and output last_step.

Test Plan:
1. Nominal run: rstb for 2 cycles, start_valid=1 at cycle 0, out_ready=1.
   - init_round at cycle 1 only; round_ing at cycles 2..33; finalize at 34; out_valid at 35; start_ready=1 again at 36.
2. Sigma wrap: in run 1, sample (round_idx, step_idx, sigma_idx).
   - (9,1,9) at cycle 21; (10,0,0) at 22; (15,1,5) at 33.
3. Backpressure: out_ready=0 for 5 DONE cycles, then 1.
   - out_valid high for exactly 6 cycles; no second finalize; start_valid during this window is not accepted.
4. Abort mid-round: abort=1 at cycle 16 (round 7, step 0).
   - IDLE at cycle 17, counters 0, finalize and out_valid never asserted; a fresh start then completes normally.
5. Reset mid-operation: rstb=1 at cycle 20 with abort also high.
   - All outputs 0 and start_ready=1 from cycle 21; the next run has init_round exactly once.
6. Busy-time start: hold start_valid=1 continuously with out_ready=1.
   - Starts are accepted only in IDLE, every 36 cycles; exactly one init_round per accepted start.
